// File: rtl/rv32ic_fetch_pkg.sv
// Shared types for the RV32IC fetch aligner: halfword type, the RV16 overlay
// union used by the downstream expander, the compressed-opcode test and the
// aligned-fetch output bundle. No ports.
package rv32ic_fetch_pkg;

  typedef logic [15:0] halfword_t;

  // Opcode bits [1:0] of a full-length (32-bit) instruction.
  localparam logic [1:0] OPC_FULL = 2'b11;

  // CI format: c.li, c.addi, c.lui, ...
  typedef struct packed {
    logic [2:0] funct3;
    logic       imm_hi;
    logic [4:0] rd_rs1;
    logic [4:0] imm_lo;
    logic [1:0] op;
  } rv16_ci_t;

  // CR format: c.mv, c.add, c.jr, ...
  typedef struct packed {
    logic [3:0] funct4;
    logic [4:0] rd_rs1;
    logic [4:0] rs2;
    logic [1:0] op;
  } rv16_cr_t;

  // Low halfword of the aligned instruction as seen by the expander.
  typedef union packed {
    halfword_t raw;
    rv16_ci_t  ci;
    rv16_cr_t  cr;
  } rv32ic_rv16_t;

  // Aligned fetch output bundle for the decode stage.
  typedef struct packed {
    logic [31:0] instr;
    logic        is_c;
    logic [31:0] pc;
  } fetch_out_t;

  // Masking with a constant keeps the whole halfword referenced; only the
  // opcode bits decide the length.
  function automatic logic is_compressed(input halfword_t hw);
    return (hw & 16'h0003) != {14'h0, OPC_FULL};
  endfunction

endpackage

// File: rtl/rv32ic_fetch_aligner_hw_buffer.sv
// Halfword circular FIFO with push-1/push-2, pop-1/pop-2, flush and 2-entry peek.
// Ports: push_vld/push_two/push_dat (push_two=0 pushes only push_dat[31:16]),
//        pop_vld/pop_two, flush (clears occupancy), cnt, peek0 (head), peek1.
module rv32ic_hw_buffer
  import rv32ic_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic             push_two,
  input  logic [31:0]      push_dat,
  input  logic             pop_vld,
  input  logic             pop_two,
  input  logic             flush,
  output logic [CNT_W-1:0] cnt,
  output halfword_t        peek0,
  output halfword_t        peek1
);

  halfword_t        mem_q [DEPTH];
  halfword_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_push, n_pop;

  // Pointer advance with wrap; works for non power-of-two depths too.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    n_push = '0;
    n_pop  = '0;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_vld) begin
        if (push_two) begin
          mem_d[wr_q]             = push_dat[15:0];
          mem_d[ptr_add(wr_q, 1)] = push_dat[31:16];
          wr_d                    = ptr_add(wr_q, 2);
          n_push                  = CNT_W'(2);
        end else begin
          mem_d[wr_q] = push_dat[31:16];
          wr_d        = ptr_add(wr_q, 1);
          n_push      = CNT_W'(1);
        end
      end
      if (pop_vld) begin
        rd_d  = ptr_add(rd_q, pop_two ? 2 : 1);
        n_pop = pop_two ? CNT_W'(2) : CNT_W'(1);
      end
      cnt_d = cnt_q + n_push - n_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign peek0 = mem_q[rd_q];
  assign peek1 = mem_q[ptr_add(rd_q, 1)];

endmodule

// File: rtl/rv32ic_fetch_aligner.sv
// Aligns word-aligned 32-bit fetch words into one RV32IC instruction per handshake.
// Ports: in_valid/in_ready/in_data (fetch words), flush/flush_pc (redirect),
//        out_valid/out_ready/out_instr/out_is_c/out_pc (aligned instruction).
module rv32ic_fetch_aligner
  import rv32ic_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BUF_HW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic              out_is_c,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int               CNT_W = $clog2(BUF_HW + 1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  // Accept only when a full two-halfword push fits regardless of pops.
  localparam logic [CNT_W-1:0] ROOM  = CNT_W'(BUF_HW - 2);

  logic [CNT_W-1:0]  cnt;
  halfword_t         hw0, hw1;
  rv32ic_rv16_t      lo_u;
  logic              head_c, have1, have2, push, pop;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              skip_q, skip_d;
  logic              live_q, live_d;

  assign head_c = is_compressed(hw0);
  assign have1  = (cnt != '0);
  assign have2  = (cnt >= TWO);

  // live_q keeps in_ready low through reset until the first clock edge.
  assign in_ready  = live_q && !flush && (cnt <= ROOM);
  assign out_valid = head_c ? have1 : have2;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign lo_u      = hw0;
  assign out_instr = {(have2 && !head_c) ? hw1 : 16'h0, lo_u};
  assign out_is_c  = have1 && head_c;
  assign out_pc    = pc_q;

  always_comb begin
    pc_d   = pc_q;
    skip_d = skip_q;
    live_d = 1'b1;
    if (flush) begin
      // Redirect to a halfword address: the first word's low half is stale.
      pc_d   = flush_pc;
      skip_d = flush_pc[1];
    end else begin
      if (pop)  pc_d   = pc_q + (head_c ? ADDR_W'(2) : ADDR_W'(4));
      if (push) skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      skip_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      skip_q <= skip_d;
      live_q <= live_d;
    end
  end

  rv32ic_hw_buffer #(
    .DEPTH (BUF_HW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push),
    .push_two (!skip_q),
    .push_dat (in_data),
    .pop_vld  (pop),
    .pop_two  (!head_c),
    .flush    (flush),
    .cnt      (cnt),
    .peek0    (hw0),
    .peek1    (hw1)
  );

  a_flush_pc_even: assert property (@(posedge clk) disable iff (!rst_n) flush |-> !flush_pc[0]);

endmodule

// File: tb/tb_rv32ic_fetch_aligner.sv
module tb_rv32ic_fetch_aligner;

  localparam int BUF_HW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_is_c;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  rv32ic_fetch_aligner #(.ADDR_W(32), .BUF_HW(BUF_HW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_is_c  (out_is_c),
    .out_pc    (out_pc)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } rec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: plain halfword queue plus PC and skip flag.
  logic [15:0] mq[$];
  logic [31:0] mpc;
  logic        mskip;
  logic        mlive;
  rec_t        got[$];
  logic [15:0] hw_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic [31:0] fpc);
    logic        c0, exp_ov, exp_ir, acc, pp;
    logic [15:0] h0;
    logic [31:0] exp_instr;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; flush_pc = fpc;
    #1;
    c0 = 1'b0;
    h0 = '0;
    if (mq.size() > 0) begin
      h0 = mq[0];
      c0 = (h0[1:0] != 2'b11);
    end
    exp_ov = (mq.size() >= 1 && c0) || (mq.size() >= 2);
    exp_ir = mlive && !fl && (mq.size() <= BUF_HW - 2);
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    if (exp_ov) begin
      exp_instr = c0 ? {16'h0, h0} : {mq[1], h0};
      chk("out_instr", 64'(out_instr), 64'(exp_instr));
      chk("out_is_c", 64'(out_is_c), 64'(c0));
      chk("out_pc", 64'(out_pc), 64'(mpc));
    end
    acc = iv && exp_ir;
    pp  = exp_ov && ordy && !fl;
    if (pp) got.push_back('{instr: out_instr, pc: out_pc, c: out_is_c});
    if (fl) begin
      mq.delete();
      mpc   = fpc;
      mskip = fpc[1];
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        if (!c0) void'(mq.pop_front());
        mpc = mpc + (c0 ? 32'd2 : 32'd4);
      end
      if (acc) begin
        if (!mskip) begin
          mq.push_back(d[15:0]);
          hw_log.push_back(d[15:0]);
        end
        mq.push_back(d[31:16]);
        hw_log.push_back(d[31:16]);
        mskip = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic log_chk(input int idx, input logic [31:0] ei, input logic [31:0] ep, input logic ec);
    if (idx < got.size()) begin
      chk("log_instr", 64'(got[idx].instr), 64'(ei));
      chk("log_pc", 64'(got[idx].pc), 64'(ep));
      chk("log_c", 64'(got[idx].c), 64'(ec));
    end else begin
      chk("log_len", 64'(got.size()), 64'(idx + 1));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd0);
    chk("rel_out_pc", 64'(out_pc), 64'd0);
    chk("rel_out_instr", 64'(out_instr), 64'd0);
    chk("rel_out_is_c", 64'(out_is_c), 64'd0);
    mq.delete();
    mpc = '0; mskip = 1'b0;
    mlive = 1'b1;  // next checked cycle follows a clock edge
    got.delete();
  endtask

  initial begin
    logic [31:0] w;
    int          k;
    mpc = '0; mskip = 1'b0; mlive = 1'b0;

    // Two 32-bit instructions back to back.
    do_reset();
    cycle(1'b1, 32'h00130093, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 32'h00230113, 1'b1, 1'b0, 32'h0);
    idle(3);
    log_chk(0, 32'h00130093, 32'h0, 1'b0);
    log_chk(1, 32'h00230113, 32'h4, 1'b0);

    // Two compressed instructions in one word.
    got.delete();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 32'h41014505, 1'b1, 1'b0, 32'h0);
    idle(3);
    log_chk(0, 32'h00004505, 32'h0, 1'b1);
    log_chk(1, 32'h00004101, 32'h2, 1'b1);

    // 32-bit instruction straddling two words.
    got.delete();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    cycle(1'b1, 32'h00934505, 1'b1, 1'b0, 32'h0);
    idle(2);
    cycle(1'b1, 32'h12340010, 1'b1, 1'b0, 32'h0);
    idle(3);
    log_chk(0, 32'h00004505, 32'h0, 1'b1);
    log_chk(1, 32'h00100093, 32'h2, 1'b0);
    log_chk(2, 32'h00001234, 32'h6, 1'b1);

    // Halfword redirect; word offered during the flush must not be taken.
    got.delete();
    cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h102);
    cycle(1'b1, 32'h4505FFFF, 1'b1, 1'b0, 32'h0);
    idle(2);
    log_chk(0, 32'h00004505, 32'h102, 1'b1);
    chk("redirect_count", 64'(got.size()), 64'd1);

    // PC wraps past all-ones with a straddling instruction.
    got.delete();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFE);
    cycle(1'b1, 32'h00931111, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 32'h45050010, 1'b1, 1'b0, 32'h0);
    idle(3);
    log_chk(0, 32'h00100093, 32'hFFFFFFFE, 1'b0);
    log_chk(1, 32'h00004505, 32'h00000002, 1'b1);

    // Consumer stall while streaming compressed words, then release.
    got.delete();
    hw_log.delete();
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    k = 0;
    for (int i = 0; i < 13; i++) begin
      w = {16'h4101 + 16'(k << 4), 16'h4505 + 16'(k << 4)};
      cycle(i < 10, w, i >= 5, 1'b0, 32'h0);
      if (hw_log.size() == 2 * (k + 1)) k++;
    end
    idle(6);
    chk("stall_count", 64'(got.size()), 64'(hw_log.size()));
    for (int i = 0; i < got.size() && i < hw_log.size(); i++) begin
      chk("stall_instr", 64'(got[i].instr), 64'({16'h0, hw_log[i]}));
      chk("stall_pc", 64'(got[i].pc), 64'(2 * i));
    end

    // Asynchronous reset mid-stream with three halfwords buffered.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h102);
    cycle(1'b1, 32'h45054505, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h45014109, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    do_reset();
    idle(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic        fl;
      logic [31:0] fpc;
      fl  = ($urandom_range(39) == 0);
      fpc = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(3) == 0) fpc = 32'hFFFF_FFF0 | (fpc & 32'hE);
      cycle($urandom_range(3) != 0, $urandom, $urandom_range(3) != 0, fl, fpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
